// File: rtl/rand_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rand_share_ctrl
// Purpose  : Shares one free-running LFSR random source among N_REQ consumers.
//            Round-robin arbitration hands a sampled random word to one
//            requester at a time. Grants are separated by at least SPACING
//            LFSR shifts, so consecutive consumers never see overlapping bit
//            histories. A frozen LFSR output is detected, and the LFSR is
//            pulsed back into reset to recover.
// Ports    : CLK       - system clock
//            RST       - synchronous active-high reset
//            rnd       - LFSR output word (bit WIDTH-1 = oldest stage)
//            req       - level requests, held until granted
//            grant     - one-hot single-cycle grant pulse
//            rdata     - random word delivered with grant
//            busy      - spacing window active, no grant possible
//            lfsr_rst  - single-cycle LFSR reset pulse on lock-up
//            recov_cnt - saturating count of lock-up recoveries
// Revision : 1.0 - initial release
// ============================================================================
module rand_share_ctrl #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 10,
    parameter int SPACING   = 10,
    parameter int STALL_LIM = 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] rnd,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [WIDTH-1:0] rdata,
    output logic             busy,
    output logic             lfsr_rst,
    output logic [3:0]       recov_cnt
);

    localparam int c_SW = $clog2(SPACING) + 1;
    localparam int c_PW = $clog2(N_REQ);
    localparam int c_TW = $clog2(STALL_LIM + 1);

    localparam logic [c_SW-1:0]  c_SP_LOAD    = c_SW'(SPACING - 1);
    localparam logic [c_PW-1:0]  c_PTR_RST    = c_PW'(N_REQ - 1);
    localparam logic [c_TW-1:0]  c_STALL_TRIP = c_TW'(STALL_LIM - 1);
    localparam logic [c_TW-1:0]  c_STALL_MAX  = c_TW'(STALL_LIM);
    localparam logic [N_REQ-1:0] c_ONE        = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [c_SW-1:0]  r_space;
    logic [c_PW-1:0]  r_rr_ptr;
    logic [WIDTH-1:0] r_prev_rnd;
    logic [c_TW-1:0]  r_stall;

    logic             w_fresh;
    logic             w_found;
    logic [c_PW-1:0]  w_winner;
    logic [c_PW-1:0]  w_idx;
    logic             w_lock;
    logic             w_grant;

    // (p + k) mod N_REQ, computed in int so non-power-of-two N_REQ never
    // yields an index past the last requester.
    function automatic logic [c_PW-1:0] wrap_add(input logic [c_PW-1:0] p,
                                                 input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return c_PW'(s);
    endfunction

    assign w_fresh = (rnd != r_prev_rnd);

    // Round-robin scan starting just after the last winner; the last
    // winner itself is checked last.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = wrap_add(r_rr_ptr, i);
            if (!w_found && req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    // Lock-up and grant are mutually exclusive (one needs a stale sample,
    // the other a fresh one), so lock-up priority falls out naturally.
    assign w_lock  = !w_fresh && !lfsr_rst && (r_stall == c_STALL_TRIP);
    assign w_grant = (r_space == '0) && w_found && w_fresh && !lfsr_rst;

    always_ff @(posedge CLK) begin
        if (RST) begin
            grant      <= '0;
            rdata      <= '0;
            busy       <= 1'b0;
            lfsr_rst   <= 1'b0;
            recov_cnt  <= '0;
            r_space    <= '0;
            r_rr_ptr   <= c_PTR_RST;
            r_prev_rnd <= '0;
            r_stall    <= '0;
        end else begin
            r_prev_rnd <= rnd;

            // Lock-up watchdog
            lfsr_rst <= 1'b0;
            if (lfsr_rst) begin
                r_stall <= '0;
            end else if (w_lock) begin
                lfsr_rst <= 1'b1;
                r_stall  <= '0;
                if (recov_cnt != 4'hF) recov_cnt <= recov_cnt + 4'd1;
            end else if (w_fresh) begin
                r_stall <= '0;
            end else if (r_stall != c_STALL_MAX) begin
                r_stall <= r_stall + 1'b1;
            end

            // Arbitration and spacing window; busy mirrors the next r_space.
            if (w_grant) begin
                grant    <= c_ONE << w_winner;
                rdata    <= rnd;
                r_rr_ptr <= w_winner;
                r_space  <= c_SP_LOAD;
                busy     <= (c_SP_LOAD != '0);
            end else begin
                grant <= '0;
                if (r_space != '0) r_space <= r_space - 1'b1;
                busy  <= (r_space > c_SW'(1));
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rand_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rand_share_ctrl
// Purpose  : Directed self-checking bench for rand_share_ctrl with default
//            parameters (N_REQ=4, WIDTH=10, SPACING=10, STALL_LIM=3).
//            The bench drives rnd itself: either a counter that advances
//            every cycle (always fresh) or a held constant (stuck LFSR).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rand_share_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] rnd;
    logic [3:0] req;
    logic [3:0] grant;
    logic [9:0] rdata;
    logic       busy;
    logic       lfsr_rst;
    logic [3:0] recov_cnt;

    int   n_chk  = 0;
    int   n_fail = 0;
    bit   run    = 1'b0;
    logic [9:0] exp_rd;
    logic [3:0] exp_g;
    int   pulses;

    rand_share_ctrl #(
        .N_REQ(4), .WIDTH(10), .SPACING(10), .STALL_LIM(3)
    ) dut (
        .CLK(clk), .RST(rst), .rnd(rnd), .req(req),
        .grant(grant), .rdata(rdata), .busy(busy),
        .lfsr_rst(lfsr_rst), .recov_cnt(recov_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock edge; outputs are sampled 1 time unit later, then the
    // counter source advances for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        if (run) rnd = rnd + 10'd1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    initial begin
        rst = 1'b1; rnd = 10'd0; req = 4'b0000;
        cyc(); cyc();
        // Reset state
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_rdata", 32'(rdata), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        check("rst_lfsr",  32'(lfsr_rst), 32'h0);
        check("rst_recov", 32'(recov_cnt), 32'h0);

        // 1: counter from 0; the first edge sees rnd==prev_rnd==0
        rst = 1'b0; req = 4'b0001; run = 1'b1;
        cyc();
        check("t1_nofresh", 32'(grant), 32'h0);
        exp_rd = rnd;
        cyc();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_rdata", 32'(rdata), 32'(exp_rd));
        check("t1_busy",  32'(busy), 32'h1);
        for (int k = 0; k < 8; k++) begin
            cyc();
            check("t1_gap_grant", 32'(grant), 32'h0);
            check("t1_gap_busy",  32'(busy), 32'h1);
        end
        cyc();
        check("t1_busy_end", 32'(busy), 32'h0);
        check("t1_nogrant",  32'(grant), 32'h0);
        exp_rd = rnd;
        cyc();
        check("t1_grant2", 32'(grant), 32'h1);
        check("t1_rdata2", 32'(rdata), 32'(exp_rd));

        // 2: all requesting, rotation 1,2,3,0 each 10 edges apart
        req = 4'b1111;
        for (int n = 0; n < 4; n++) begin
            for (int k = 0; k < 9; k++) begin
                cyc();
                check("t2_gap", 32'(grant), 32'h0);
            end
            exp_g  = (n == 3) ? 4'b0001 : (4'b0010 << n);
            exp_rd = rnd;
            cyc();
            check("t2_grant", 32'(grant), 32'(exp_g));
            check("t2_rdata", 32'(rdata), 32'(exp_rd));
        end

        // 3: ptr=0, req 0101, req[1] raised mid-window -> 1 wins, then 2
        req = 4'b0101;
        for (int k = 0; k < 4; k++) cyc();
        req = 4'b0111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("t3_gap", 32'(grant), 32'h0);
        end
        cyc();
        check("t3_grant1", 32'(grant), 32'b0010);
        req = 4'b0101;
        for (int k = 0; k < 9; k++) cyc();
        cyc();
        check("t3_grant2", 32'(grant), 32'b0100);

        // 4: stuck at 3FF; pulse on 4th edge, then release to 0 and resume
        req = 4'b1111; run = 1'b0; rnd = 10'h3FF;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t4_pre_lfsr", 32'(lfsr_rst), 32'h0);
            check("t4_pre_grant", 32'(grant), 32'h0);
        end
        cyc();
        check("t4_pulse", 32'(lfsr_rst), 32'h1);
        check("t4_recov", 32'(recov_cnt), 32'h1);
        rnd = 10'h000; run = 1'b1;
        cyc();
        check("t4_pulse_end", 32'(lfsr_rst), 32'h0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            check("t4_wait", 32'(grant), 32'h0);
        end
        exp_rd = rnd;
        cyc();
        check("t4_resume", 32'(grant), 32'b1000);
        check("t4_rdata",  32'(rdata), 32'(exp_rd));

        // 5: stuck at 155 for 80 edges; pulse every 4 edges -> 20 pulses
        req = 4'b0000; run = 1'b0; rnd = 10'h155; pulses = 0;
        cyc();
        req = 4'b0001;
        for (int k = 1; k < 80; k++) begin
            cyc();
            if (lfsr_rst) pulses++;
            check("t5_nogrant", 32'(grant), 32'h0);
        end
        check("t5_pulses", 32'(pulses), 32'd20);
        check("t5_recov_sat", 32'(recov_cnt), 32'hF);
        check("t5_last_pulse", 32'(lfsr_rst), 32'h1);

        // 6: resume, grant, RST mid-window, requester 0 wins again
        rnd = 10'h000; run = 1'b1;
        cyc();
        check("t6_blocked", 32'(grant), 32'h0);
        cyc();
        check("t6_grant", 32'(grant), 32'b0001);
        for (int k = 0; k < 4; k++) cyc();
        check("t6_busy_pre", 32'(busy), 32'h1);
        req = 4'b0100; rst = 1'b1;
        cyc();
        check("t6_rst_busy",  32'(busy), 32'h0);
        check("t6_rst_grant", 32'(grant), 32'h0);
        check("t6_rst_recov", 32'(recov_cnt), 32'h0);
        check("t6_rst_rdata", 32'(rdata), 32'h0);
        rst = 1'b0; req = 4'b1111;
        exp_rd = rnd;
        cyc();
        check("t6_first", 32'(grant), 32'b0001);
        check("t6_rdata", 32'(rdata), 32'(exp_rd));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
